// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: boot/run/drain sequencing, hazard resolution and stall
// accounting for the 5-stage IF/ID/EX/MEM/WB pipeline.
module pipeline_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int ADDR_WIDTH  = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_enable_i,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  ex_reg_we_i,
    input  logic                  ex_wdata_mux_i,
    input  logic [ADDR_WIDTH-1:0] ex_dest_reg_i,
    input  logic                  mem_branch_taken_i,
    input  logic                  dmem_busy_i,
    output logic [1:0]            pc_mux_o,
    output logic                  if_id_en_o,
    output logic                  id_ex_en_o,
    output logic                  ex_mem_en_o,
    output logic                  mem_wb_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic                  running_o,
    output logic [CNT_WIDTH-1:0]  stall_count_o
);

    localparam logic [1:0] CU_PC_BOOT  = 2'b00;
    localparam logic [1:0] CU_PC_STALL = 2'b01;
    localparam logic [1:0] CU_PC_NEXT  = 2'b10;

    // Shared boot/drain counter; must hold BOOT_CYCLES-1 and the drain start of 3.
    localparam int CW = $clog2(BOOT_CYCLES + 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BOOT  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic w_active;
    logic w_load_use;
    logic w_stall;

    // Load in EX whose destination feeds a source read by the instruction in ID.
    // x0 is never a real producer, so it never stalls.
    assign w_load_use = ex_reg_we_i & ex_wdata_mux_i & (ex_dest_reg_i != '0) &
                        ((id_rs1_used_i & (id_rs1_addr_i == ex_dest_reg_i)) |
                         (id_rs2_used_i & (id_rs2_addr_i == ex_dest_reg_i)));

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);

    // A stall cycle: memory wait, or a load-use bubble not overridden by a branch.
    assign w_stall = w_active & (dmem_busy_i | (~mem_branch_taken_i & w_load_use));

    // Per-stage enables, flushes and PC select from state plus live hazards.
    always_comb begin
        pc_mux_o       = CU_PC_BOOT;
        if_id_en_o     = 1'b0;
        id_ex_en_o     = 1'b0;
        ex_mem_en_o    = 1'b0;
        mem_wb_en_o    = 1'b0;
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = 1'b1;
        ex_mem_flush_o = 1'b1;
        case (r_state)
            S_IDLE: ;
            S_BOOT: begin
                if_id_en_o  = 1'b1;
                id_ex_en_o  = 1'b1;
                ex_mem_en_o = 1'b1;
                mem_wb_en_o = 1'b1;
            end
            default: begin
                if (dmem_busy_i) begin
                    // Freeze everything; a pending branch stays in EX/MEM.
                    pc_mux_o       = CU_PC_STALL;
                    if_id_flush_o  = 1'b0;
                    id_ex_flush_o  = 1'b0;
                    ex_mem_flush_o = 1'b0;
                end else if (mem_branch_taken_i) begin
                    // Redirect and squash the three younger instructions.
                    pc_mux_o    = CU_PC_NEXT;
                    if_id_en_o  = 1'b1;
                    id_ex_en_o  = 1'b1;
                    ex_mem_en_o = 1'b1;
                    mem_wb_en_o = 1'b1;
                end else if (w_load_use) begin
                    // Hold IF/ID, drop a bubble into EX, let older work drain.
                    pc_mux_o       = CU_PC_STALL;
                    id_ex_en_o     = 1'b1;
                    ex_mem_en_o    = 1'b1;
                    mem_wb_en_o    = 1'b1;
                    if_id_flush_o  = 1'b0;
                    ex_mem_flush_o = 1'b0;
                end else begin
                    pc_mux_o       = CU_PC_NEXT;
                    if_id_en_o     = 1'b1;
                    id_ex_en_o     = 1'b1;
                    ex_mem_en_o    = 1'b1;
                    mem_wb_en_o    = 1'b1;
                    if_id_flush_o  = 1'b0;
                    id_ex_flush_o  = 1'b0;
                    ex_mem_flush_o = 1'b0;
                end
                // While draining, nothing new is fetched into the pipe.
                if (r_state == S_DRAIN) begin
                    pc_mux_o      = CU_PC_STALL;
                    if_id_flush_o = 1'b1;
                end
            end
        endcase
    end

    assign running_o     = (r_state == S_RUN);
    assign stall_count_o = r_stall_cnt;

    // Sequencing FSM with boot/drain counter and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            case (r_state)
                S_IDLE: begin
                    if (fetch_enable_i) begin
                        r_state     <= S_BOOT;
                        r_cnt       <= CW'(BOOT_CYCLES - 1);
                        r_stall_cnt <= '0;
                    end
                end
                S_BOOT: begin
                    if (!fetch_enable_i) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RUN: begin
                    if (!fetch_enable_i) begin
                        r_state <= S_DRAIN;
                        r_cnt   <= CW'(3);
                    end
                end
                default: begin
                    // Only cycles where the pipe actually advances count toward drain.
                    if (!w_stall) begin
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: boot, hazards, drain, saturation, async reset.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_enable_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic        id_rs1_used_i, id_rs2_used_i;
    logic        ex_reg_we_i, ex_wdata_mux_i;
    logic [4:0]  ex_dest_reg_i;
    logic        mem_branch_taken_i, dmem_busy_i;
    logic [1:0]  pc_mux_o;
    logic        if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
    logic        if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
    logic        running_o;
    logic [15:0] stall_count_o;

    int n_err = 0;
    int n_chk = 0;

    pipeline_ctrl #(.BOOT_CYCLES(4), .ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_enable_i(fetch_enable_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_reg_we_i(ex_reg_we_i), .ex_wdata_mux_i(ex_wdata_mux_i),
        .ex_dest_reg_i(ex_dest_reg_i), .mem_branch_taken_i(mem_branch_taken_i),
        .dmem_busy_i(dmem_busy_i), .pc_mux_o(pc_mux_o),
        .if_id_en_o(if_id_en_o), .id_ex_en_o(id_ex_en_o),
        .ex_mem_en_o(ex_mem_en_o), .mem_wb_en_o(mem_wb_en_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
        .ex_mem_flush_o(ex_mem_flush_o), .running_o(running_o),
        .stall_count_o(stall_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // en = {if_id, id_ex, ex_mem, mem_wb}, fl = {if_id, id_ex, ex_mem}
    task automatic chk_outs(input string tag, input logic [1:0] pc, input logic [3:0] en,
                            input logic [2:0] fl, input logic run);
        chk({tag, ".pc"}, 32'(pc_mux_o), 32'(pc));
        chk({tag, ".en"}, 32'({if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o}), 32'(en));
        chk({tag, ".fl"}, 32'({if_id_flush_o, id_ex_flush_o, ex_mem_flush_o}), 32'(fl));
        chk({tag, ".run"}, 32'(running_o), 32'(run));
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_haz();
        id_rs1_addr_i = 0; id_rs2_addr_i = 0;
        id_rs1_used_i = 0; id_rs2_used_i = 0;
        ex_reg_we_i = 0; ex_wdata_mux_i = 0; ex_dest_reg_i = 0;
        mem_branch_taken_i = 0; dmem_busy_i = 0;
    endtask

    task automatic set_lw(input logic [4:0] dest, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        ex_reg_we_i = 1; ex_wdata_mux_i = 1; ex_dest_reg_i = dest;
        id_rs1_addr_i = rs1; id_rs1_used_i = u1;
        id_rs2_addr_i = rs2; id_rs2_used_i = u2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; fetch_enable_i = 0; clr_haz();
        #3;
        chk_outs("reset", 2'b00, 4'b0000, 3'b111, 1'b0);
        chk("reset.cnt", 32'(stall_count_o), 0);
        #9 rst_n = 1; fetch_enable_i = 1;
        #1 chk_outs("idle", 2'b00, 4'b0000, 3'b111, 1'b0);

        // Four BOOT cycles, then RUN
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk_outs($sformatf("boot%0d", i), 2'b00, 4'b1111, 3'b111, 1'b0);
        end
        cyc(); #1;
        chk_outs("run0", 2'b10, 4'b1111, 3'b000, 1'b1);
        chk("run0.cnt", 32'(stall_count_o), 0);

        // Load-use on rs1
        set_lw(5, 5, 1, 0, 0); #1;
        chk_outs("lu_rs1", 2'b01, 4'b0111, 3'b010, 1'b1);
        cyc(); clr_haz(); #1;
        chk_outs("after_lu", 2'b10, 4'b1111, 3'b000, 1'b1);
        chk("lu.cnt", 32'(stall_count_o), 1);
        // dest=0 never stalls
        set_lw(0, 0, 1, 0, 1); #1;
        chk_outs("lu_x0", 2'b10, 4'b1111, 3'b000, 1'b1);
        cyc(); clr_haz();
        // Matching rs1 that is not used: no stall
        set_lw(9, 9, 0, 3, 1); #1;
        chk_outs("lu_unused", 2'b10, 4'b1111, 3'b000, 1'b1);
        cyc(); clr_haz(); #1;
        chk("x0.cnt", 32'(stall_count_o), 1);
        // Load-use on rs2
        set_lw(7, 2, 1, 7, 1); #1;
        chk_outs("lu_rs2", 2'b01, 4'b0111, 3'b010, 1'b1);
        cyc(); clr_haz(); #1;
        chk("rs2.cnt", 32'(stall_count_o), 2);
        // Non-load write (wdata_mux=0) does not stall
        set_lw(4, 4, 1, 0, 0); ex_wdata_mux_i = 0; #1;
        chk_outs("alu_fwd", 2'b10, 4'b1111, 3'b000, 1'b1);
        cyc(); clr_haz();

        // Branch beats load-use
        set_lw(5, 5, 1, 0, 0); mem_branch_taken_i = 1; #1;
        chk_outs("br_lu", 2'b10, 4'b1111, 3'b111, 1'b1);
        cyc(); clr_haz(); #1;
        chk("br.cnt", 32'(stall_count_o), 2);

        // Memory wait with pending branch and load-use: busy wins for 3 cycles
        for (int i = 0; i < 3; i++) begin
            dmem_busy_i = 1; mem_branch_taken_i = 1; set_lw(6, 6, 1, 0, 0); #1;
            chk_outs($sformatf("busy%0d", i), 2'b01, 4'b0000, 3'b000, 1'b1);
            cyc();
        end
        clr_haz(); mem_branch_taken_i = 1; #1;
        chk_outs("busy_br", 2'b10, 4'b1111, 3'b111, 1'b1);
        cyc(); clr_haz(); #1;
        chk("busy.cnt", 32'(stall_count_o), 5);

        // Drain: RUN cycle with fetch_enable low still acts as RUN
        fetch_enable_i = 0; #1;
        chk_outs("drain_req", 2'b10, 4'b1111, 3'b000, 1'b1);
        cyc(); #1;
        chk_outs("drain0", 2'b01, 4'b1111, 3'b100, 1'b0);
        cyc(); set_lw(5, 5, 1, 0, 0); fetch_enable_i = 1; #1;
        chk_outs("drain_lu", 2'b01, 4'b0111, 3'b110, 1'b0);
        cyc(); clr_haz(); #1;
        chk_outs("drain2", 2'b01, 4'b1111, 3'b100, 1'b0);
        cyc(); #1;
        chk_outs("drain3", 2'b01, 4'b1111, 3'b100, 1'b0);
        cyc(); #1;
        chk_outs("drain_idle", 2'b00, 4'b0000, 3'b111, 1'b0);
        chk("idle.cnt", 32'(stall_count_o), 6);

        // Re-boot clears the stall counter
        cyc(); #1;
        chk_outs("reboot", 2'b00, 4'b1111, 3'b111, 1'b0);
        chk("reboot.cnt", 32'(stall_count_o), 0);
        repeat (4) cyc();
        #1 chk("rerun", 32'(running_o), 1);

        // Saturate the stall counter with a long memory wait
        dmem_busy_i = 1;
        repeat (65540) cyc();
        #1 chk("sat.cnt", 32'(stall_count_o), 32'hFFFF);
        chk_outs("sat", 2'b01, 4'b0000, 3'b000, 1'b1);
        cyc(); #1;
        chk("sat_hold.cnt", 32'(stall_count_o), 32'hFFFF);

        // Async reset mid-cycle: IDLE outputs before any clock edge
        #1 rst_n = 0;
        #1 chk_outs("async_rst", 2'b00, 4'b0000, 3'b111, 1'b0);
        chk("async_rst.cnt", 32'(stall_count_o), 0);
        clr_haz();
        #10 rst_n = 1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing unit for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). Owns the boot/run/drain state machine, generates the fetch PC mux select (CU_PC_BOOT/STALL/NEXT), per-stage pipeline register enables and flushes, resolves load-use hazards, MEM-stage taken branches and data-memory wait, and keeps a saturating stall-cycle counter.

## Interface
- BOOT_CYCLES, 4: cycles spent in BOOT, ≥1.
- ADDR_WIDTH, 5: register address width.
- CNT_WIDTH, 16: stall counter width (CSR_WIDTH).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_enable_i  in  1  level request to run the core.
- id_rs1_addr_i / id_rs2_addr_i  in  ADDR_WIDTH  source registers of instruction in ID.
- id_rs1_used_i / id_rs2_used_i  in  1  source actually read.
- ex_reg_we_i  in  1  instruction in EX writes rd.
- ex_wdata_mux_i  in  1  WDATA_MEM (1) = load in EX.
- ex_dest_reg_i  in  ADDR_WIDTH  rd of instruction in EX.
- mem_branch_taken_i  in  1  branch/jump in MEM redirects PC.
- dmem_busy_i  in  1  data memory not ready; whole pipeline must freeze.
- pc_mux_o  out  2  CU_PC_BOOT=00, CU_PC_STALL=01, CU_PC_NEXT=10.
- if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  stage register load enable.
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o  out  1 each  stage register loads a bubble; effective only when matching enable=1.
- running_o  out  1  state is RUN.
- stall_count_o  out  CNT_WIDTH  stall cycles since last BOOT.

## Operation
- States: IDLE, BOOT, RUN, DRAIN. Reset → IDLE. Only state, boot/drain counter and stall_count are registered; all other outputs combinational from state + inputs.
- IDLE: pc_mux=BOOT, all enables 0, all flushes 1, running 0. fetch_enable_i=1 → BOOT.
- BOOT: pc_mux=BOOT, all enables 1, all flushes 1; stall_count cleared on entry. After BOOT_CYCLES cycles → RUN. fetch_enable_i=0 during BOOT → IDLE next edge.
- RUN, priority high→low, evaluated each cycle:
  - dmem_busy_i: all enables 0, pc_mux=STALL, flushes 0. Pending branch stays frozen in EX/MEM and is acted on once busy drops.
  - mem_branch_taken_i: pc_mux=NEXT, all enables 1, if_id/id_ex/ex_mem flush=1. Load-use ignored this cycle.
  - load-use: ex_reg_we_i & ex_wdata_mux_i & ex_dest_reg_i≠0 & ((rs1_used & rs1==dest) | (rs2_used & rs2==dest)) → pc_mux=STALL, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=mem_wb_en=1.
  - else: pc_mux=NEXT, all enables 1, flushes 0.
  - fetch_enable_i=0 → DRAIN next edge (current cycle still evaluated as RUN).
- DRAIN: same hazard rules as RUN but pc_mux forced STALL and if_id_flush forced 1. Drain counter starts at 3, decrements only on cycles with no dmem_busy and no load-use stall; reaching 0 → IDLE. fetch_enable_i ignored until IDLE.
- stall_count: +1 on every RUN or DRAIN cycle with dmem_busy_i or load-use stall active; saturates at all-ones; holds in IDLE.

## Timing
- Reset (async, any time incl. mid-BOOT/RUN/DRAIN): state=IDLE immediately, stall_count=0, counters cleared; outputs take IDLE values without waiting for clk.
- fetch_enable_i sampled at edge k in IDLE → BOOT from k; RUN starts at edge k+BOOT_CYCLES.
- Hazard outputs respond in the same cycle as inputs (zero latency); load-use bubble costs exactly 1 cycle.
- Taken branch: 3 younger instructions squashed; first fetched target reaches ID one cycle after redirect.
- dmem_busy_i for N cycles freezes pipeline exactly N cycles.
- Simultaneous busy + branch + load-use: busy wins; branch wins over load-use.
- ex_dest_reg_i=0 never stalls.

## Test plan
- Reset/boot: rst_n low→high, fetch_enable_i=1 at cycle 0 → pc_mux=00 for 4 cycles with flushes=1, then running_o=1, pc_mux=10, enables all 1.
- Load-use: EX lw x5 (we=1, wdata_mux=1, dest=5), ID rs1=5 used → pc_mux=01, if_id_en=0, id_ex_flush=1 for 1 cycle, stall_count 0→1; repeat with dest=0 → no stall.
- Branch vs load-use: mem_branch_taken_i=1 with load-use hazard → pc_mux=10, three flushes=1, stall_count unchanged.
- Memory wait: dmem_busy_i=1 for 3 cycles with mem_branch_taken_i=1 → all enables 0, pc_mux=01 for 3 cycles, then branch flush on 4th; stall_count +3.
- Drain: fetch_enable_i=0 in RUN with one load-use stall during DRAIN → pc_mux=01, if_id_flush=1, IDLE after 4 cycles; fetch_enable_i=1 mid-drain ignored.
- Async reset mid-RUN with stall_count=0xFFFF (saturated after forced stalls) → immediately IDLE outputs, stall_count=0.
